// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART RX frame-controller types, FIFO entry layout and helpers
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } rx_state_e;

  localparam int BYTE_LSB = 0;
  localparam int PAR_BIT  = 8;
  localparam int STOP_BIT = 9;
  localparam int ENTRY_W  = 10;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] b,
                                                    input logic       par_err,
                                                    input logic       stop_err);
    logic [ENTRY_W-1:0] e;
    e                 = '0;
    e[BYTE_LSB +: 8]  = b;
    e[PAR_BIT]        = par_err;
    e[STOP_BIT]       = stop_err;
    return e;
  endfunction

  // Saturating counter step; an event in the clearing cycle still counts.
  function automatic logic [7:0] sat_step(input logic [7:0] c,
                                          input logic       inc,
                                          input logic       clr);
    if (clr)
      return {7'd0, inc};
    else if (inc && (c != 8'hFF))
      return c + 8'd1;
    else
      return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module : uart_rx_fifo
// Brief  : Result FIFO, power-of-two DEPTH, reads zero when empty
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module : uart_rx_ctrl
// Brief  : UART RX frame controller: start detect, parity shadow, timeout,
//          result FIFO and sticky status. Error counters built only with
//          UART_RX_ERRCNT_EN defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_enable,
  input  logic         cfg_par_en,
  input  logic         cfg_par_typ,
  input  logic         clr_status,
  input  logic         rx_line,
  output logic         rx_start,
  output logic         rx_par_en,
  output logic         rx_par_typ,
  input  logic [7:0]   rx_p_data,
  input  logic         rx_data_valid,
  input  logic         rx_par_error,
  input  logic         rx_stop_error,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [9:0]   m_data,
  output logic         busy,
  output logic         overrun,
  output logic         timeout,
  output logic [7:0]   par_err_cnt,
  output logic [7:0]   stop_err_cnt,
  output logic [7:0]   ovr_cnt
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  rx_state_e     state_q;
  logic          par_en_q;
  logic          par_typ_q;
  logic [CW-1:0] tcnt_q;
  logic          timeout_q;
  logic          overrun_q;

  logic          w_idle;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_tmo;
  logic          w_full;
  logic          w_empty;

  assign w_idle     = (state_q == ST_IDLE);
  // Gated by rst so no start is issued while reset is held.
  assign rx_start   = rst & w_idle & rx_enable & ~rx_line;
  assign rx_par_en  = w_idle ? cfg_par_en  : par_en_q;
  assign rx_par_typ = w_idle ? cfg_par_typ : par_typ_q;
  assign busy       = ~w_idle;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

  assign w_push = (state_q == ST_BUSY) & rx_data_valid;
  assign w_pop  = m_valid & m_ready;
  assign w_drop = w_push & w_full & ~w_pop;
  assign w_tmo  = (state_q == ST_BUSY) & ~rx_data_valid &
                  (tcnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_start) begin
            par_en_q  <= cfg_par_en;
            par_typ_q <= cfg_par_typ;
            tcnt_q    <= '0;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          tcnt_q <= tcnt_q + CW'(1);
          if (rx_data_valid || w_tmo) state_q <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (rx_line) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (w_tmo)           timeout_q <= 1'b1;
      else if (clr_status) timeout_q <= 1'b0;

      if (w_drop)          overrun_q <= 1'b1;
      else if (clr_status) overrun_q <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (pack_entry(rx_p_data, rx_par_error, rx_stop_error)),
    .rdata_o (m_data),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign m_valid = ~w_empty;

`ifdef UART_RX_ERRCNT_EN
  logic [7:0] par_cnt_q;
  logic [7:0] stop_cnt_q;
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_cnt_q  <= 8'd0;
      stop_cnt_q <= 8'd0;
      ovr_cnt_q  <= 8'd0;
    end else begin
      par_cnt_q  <= sat_step(par_cnt_q,  w_push & rx_par_error,  clr_status);
      stop_cnt_q <= sat_step(stop_cnt_q, w_push & rx_stop_error, clr_status);
      ovr_cnt_q  <= sat_step(ovr_cnt_q,  w_drop,                 clr_status);
    end
  end

  assign par_err_cnt  = par_cnt_q;
  assign stop_err_cnt = stop_cnt_q;
  assign ovr_cnt      = ovr_cnt_q;
`else
  assign par_err_cnt  = 8'd0;
  assign stop_err_cnt = 8'd0;
  assign ovr_cnt      = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module : tb_uart_rx_ctrl
// Brief  : Scoreboard bench for uart_rx_ctrl (honours UART_RX_ERRCNT_EN)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable, cfg_par_en, cfg_par_typ, clr_status, rx_line;
  logic       rx_start, rx_par_en, rx_par_typ;
  logic [7:0] rx_p_data;
  logic       rx_data_valid, rx_par_error, rx_stop_error;
  logic       m_valid, m_ready;
  logic [9:0] m_data;
  logic       busy, overrun, timeout;
  logic [7:0] par_err_cnt, stop_err_cnt, ovr_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];
  int         exp_par = 0, exp_stop = 0, exp_ovr = 0;
  logic [9:0] head;
  bit         drained;

  uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_enable     (rx_enable),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .clr_status    (clr_status),
    .rx_line       (rx_line),
    .rx_start      (rx_start),
    .rx_par_en     (rx_par_en),
    .rx_par_typ    (rx_par_typ),
    .rx_p_data     (rx_p_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_error  (rx_par_error),
    .rx_stop_error (rx_stop_error),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy),
    .overrun       (overrun),
    .timeout       (timeout),
    .par_err_cnt   (par_err_cnt),
    .stop_err_cnt  (stop_err_cnt),
    .ovr_cnt       (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef UART_RX_ERRCNT_EN
    check_val({tag, "_par_cnt"},  par_err_cnt,  exp_par);
    check_val({tag, "_stop_cnt"}, stop_err_cnt, exp_stop);
    check_val({tag, "_ovr_cnt"},  ovr_cnt,      exp_ovr);
`else
    check_val({tag, "_par_cnt"},  par_err_cnt,  0);
    check_val({tag, "_stop_cnt"}, stop_err_cnt, 0);
    check_val({tag, "_ovr_cnt"},  ovr_cnt,      0);
`endif
  endtask

  // Consumer side: an entry leaves at the next edge whenever valid and ready.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) check_val("sb_unexpected_entry", 1, 0);
      else                   check_val("m_data", m_data, exp_q.pop_front());
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic pe, input logic se,
                            input bit hold_low, input bit toggle_typ);
    logic exp_en, exp_typ;
    exp_en  = cfg_par_en;
    exp_typ = cfg_par_typ;
    rx_line = 1'b0;
    #1;
    check_val("rx_start_fire", rx_start, 1);
    check_val("par_en_live", rx_par_en, exp_en);
    tick;
    check_val("busy_rise", busy, 1);
    check_val("rx_start_in_busy", rx_start, 0);
    rx_line = hold_low ? 1'b0 : 1'b1;
    if (toggle_typ) cfg_par_typ = ~cfg_par_typ;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_val("par_en_shadow", rx_par_en, exp_en);
      check_val("par_typ_shadow", rx_par_typ, exp_typ);
      tick;
    end
    rx_p_data = b; rx_par_error = pe; rx_stop_error = se; rx_data_valid = 1'b1;
    @(negedge clk);
    #1;
    if (exp_q.size() < DEPTH) exp_q.push_back({se, pe, b});
    else                      exp_ovr++;
    if (pe) exp_par++;
    if (se) exp_stop++;
    tick;
    rx_data_valid = 1'b0; rx_par_error = 1'b0; rx_stop_error = 1'b0;
    check_val("m_valid_after_push", m_valid, 1);
    check_val("busy_wait_high", busy, 1);
    if (!hold_low) begin
      tick;
      check_val("busy_fall", busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rx_enable = 1'b1; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
    clr_status = 1'b0; rx_line = 1'b0; rx_p_data = 8'h00; rx_data_valid = 1'b0;
    rx_par_error = 1'b0; rx_stop_error = 1'b0; m_ready = 1'b1;

    // Reset state
    repeat (3) tick;
    check_val("rst_rx_start", rx_start, 0);
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_m_data", m_data, 0);
    check_counters("rst");
    rst = 1'b1; rx_line = 1'b1;
    tick;

    // Clean frame, even parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Parity type toggled mid-frame applies only from the next IDLE
    cfg_par_typ = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check_val("par_typ_live_after", rx_par_typ, cfg_par_typ);

    // Stop error, line held low afterwards: no retrigger
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check_val("no_retrigger_start", rx_start, 0);
      check_val("wait_high_busy", busy, 1);
    end
    rx_line = 1'b1;
    tick;
    check_val("wait_high_exit", busy, 0);
    tick;
    check_counters("post_err");

    // Overrun: consumer stalled, DEPTH+1 frames
    m_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), i[0], 1'b0, 1'b0, 1'b0);
      if (i == 0) head = m_data;
    end
    check_val("head_stable", m_data, head);
    check_val("overrun_set", overrun, 1);
    check_counters("ovr");
    m_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      tick;
      if (!m_valid) drained = 1'b1;
    end
    check_val("drain_done", drained, 1);
    m_ready = 1'b0;
    clr_status = 1'b1;
    tick;
    clr_status = 1'b0;
    exp_par = 0; exp_stop = 0; exp_ovr = 0;
    check_val("overrun_clr", overrun, 0);
    check_counters("clr");
    m_ready = 1'b1;

    // Timeout: no data_valid after start
    rx_line = 1'b0;
    #1;
    check_val("tmo_rx_start", rx_start, 1);
    tick;
    rx_line = 1'b1;
    repeat (TMO - 1) tick;
    check_val("tmo_not_yet", timeout, 0);
    check_val("tmo_busy_b15", busy, 1);
    tick;
    check_val("tmo_set_b16", timeout, 1);
    check_val("tmo_wait_high", busy, 1);
    tick;
    check_val("tmo_idle", busy, 0);
    check_val("tmo_no_push", m_valid, 0);
    clr_status = 1'b1;
    tick;
    clr_status = 1'b0;
    check_val("tmo_clr", timeout, 0);

    // Reset mid-frame with two queued entries
    m_ready = 1'b0;
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_line = 1'b0;
    tick;
    check_val("pre_rst_busy", busy, 1);
    check_val("pre_rst_m_valid", m_valid, 1);
    rst = 1'b0;
    tick;
    exp_q.delete();
    exp_par = 0; exp_stop = 0; exp_ovr = 0;
    check_val("mid_rst_m_valid", m_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    rst = 1'b1; rx_line = 1'b1; m_ready = 1'b1;
    tick;
    check_counters("post_rst");

    repeat (3) tick;
    check_val("sb_all_consumed", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-level controller for the UART receive datapath. Detects the start bit on the serial line and issues the receiver's one-cycle `start`. Holds the parity configuration stable for the whole frame and supervises completion with a timeout. Buffers each received byte with its error flags in a small FIFO behind a valid/ready interface, and sits between the receiver and the host/register side.

## Interface
Parameters:
- `DEPTH`, default 4: result FIFO entries; power of two, 2–16.
- `TIMEOUT_CYC`, default 16: cycles allowed from frame start to receiver `data_valid`; minimum 12.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `rx_enable`  in  1  permits new frame starts.
- `cfg_par_en`  in  1  parity enable for the next frame.
- `cfg_par_typ`  in  1  parity type for the next frame; 0 = even, 1 = odd.
- `clr_status`  in  1  one-cycle pulse; clears sticky flags and counters.
- `rx_line`  in  1  serial line, idle high; one bit per `clk`.
- `rx_start`  out  1  start pulse to receiver.
- `rx_par_en`  out  1  parity enable to receiver.
- `rx_par_typ`  out  1  parity type to receiver.
- `rx_p_data`  in  8  byte from receiver.
- `rx_data_valid`  in  1  receiver frame-complete strobe.
- `rx_par_error`  in  1  receiver parity error.
- `rx_stop_error`  in  1  receiver stop-bit error.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts the head entry.
- `m_data`  out  10  head entry: {stop_err, par_err, byte[7:0]}.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky: a result was dropped because the FIFO was full.
- `timeout`  out  1  sticky: a frame was aborted by timeout.
- `par_err_cnt`, `stop_err_cnt`, `ovr_cnt`  out  8 each  error counters (see Configuration).

## Operation
- States: IDLE, BUSY, WAIT_HIGH.
- IDLE:
  - `rx_start` = `rx_enable & ~rx_line`, combinational, so it is high during the start-bit cycle.
  - `rx_par_en`/`rx_par_typ` follow `cfg_*` live.
  - When `rx_start` = 1: shadow `cfg_*`, clear the timeout counter, go to BUSY.
- BUSY:
  - `rx_par_en`/`rx_par_typ` come from the shadow registers; `cfg_*` changes apply from the next frame only.
  - The counter increments each cycle.
  - On `rx_data_valid`: push {stop, par, p_data}, go to WAIT_HIGH.
  - Else, when the counter reaches `TIMEOUT_CYC-1`: set `timeout`, go to WAIT_HIGH, push nothing.
- WAIT_HIGH:
  - Stay until `rx_line` = 1, then go to IDLE.
  - A held-low line (break, or a stop error) never retriggers a frame.
- `rx_enable` deasserting mid-frame does not abort the frame; it only blocks the next start.
- `rx_start` is never high outside IDLE.
- FIFO:
  - A push is accepted when not full, or when full and popping in the same cycle.
  - Otherwise the entry is dropped and `overrun` is set.
  - A pop occurs when `m_valid & m_ready`. `m_data` is stable while `m_valid & ~m_ready`.
  - Pointers wrap modulo `DEPTH`.
  - Simultaneous push and pop on an empty FIFO: the push lands, and `m_valid` rises the next cycle.
- If `clr_status` coincides with a set event, the set wins.
- `rx_data_valid` outside BUSY is ignored.

## Timing
- Reset values:
  - state IDLE; FIFO empty.
  - `m_valid`, `busy`, `overrun`, `timeout`, counters, shadows = 0.
  - `rx_start` = 0 during reset.
  - `m_data` = 0 when empty.
- `rx_data_valid` in cycle C produces `m_valid` = 1 in C+1 (FIFO previously empty). `busy` is high from the cycle after `rx_start` until WAIT_HIGH exits.
- Timeout abort: the counter hits `TIMEOUT_CYC-1` (15 by default) without `rx_data_valid` in cycle B+15 (B = first BUSY cycle); `timeout` = 1 and state = WAIT_HIGH from B+16.
- A reset mid-frame discards the frame and all FIFO contents.

## Configuration
- `UART_RX_ERRCNT_EN` defined:
  - `par_err_cnt`, `stop_err_cnt` and `ovr_cnt` increment on each pushed-or-dropped frame with the respective flag (`ovr_cnt` on each drop).
  - Counters saturate at 255 and clear on `clr_status`.
- Not defined: the counter registers are absent and the three ports are tied to 0.

## Structure
- Shared package `uart_pkg`: state encoding, FIFO entry field offsets (`BYTE_LSB` = 0, `PAR_BIT` = 8, `STOP_BIT` = 9), and the entry width of 10.
- One sub-module: `uart_rx_fifo` (parameterised `DEPTH`, width 10, push/pop/full/empty). The FSM, shadows, timeout and status stay in the top.

## Test plan
- Line low in IDLE, `rx_enable` = 1, `cfg` = even parity; receiver returns 0xA5 with no errors → `m_data` = 0x0A5, `m_valid` for one entry; `rx_par_en` = 1 throughout BUSY.
- `cfg_par_typ` toggled mid-frame → `rx_par_typ` unchanged until the next IDLE.
- Receiver returns 0x3C with `stop_error`, line held low afterwards → `m_data` = 0x23C; no second `rx_start` until the line goes high.
- `m_ready` = 0; send `DEPTH`+1 frames → first 4 entries intact, `overrun` = 1, `ovr_cnt` = 1 (macro on), and 0 with the macro off.
- No `rx_data_valid` after start → `timeout` = 1 at B+16, no push; `clr_status` → `timeout` = 0.
- Reset asserted in BUSY with 2 entries queued → `m_valid` = 0, `busy` = 0 in the next cycle.
